type_field_extract: RTL and testbench
=====================================

# type_field_extract

Pipelined extractor that sits directly upstream of the type-lookup stage in each parser/deparser layer. It accepts a header window plus per-field type offsets (produced by the previous layer's lookup result), slices TYPE_NUM type fields out of the window, and presents them, together with the forwarded header, to the lookup stage over a valid/ready handshake. A two-entry register pipeline gives full throughput, and the block counts out-of-window offsets.

## Interface
- HEAD_WIDTH, 512: header window width in bits; HEAD_BYTES = HEAD_WIDTH/8; byte 0 = i_head[HEAD_WIDTH-1 -: 8].
- TYPE_NUM, 4: number of type fields extracted.
- TYPE_WIDTH, 16: type field width in bits; multiple of 8; TB = TYPE_WIDTH/8.
- TYPE_OFFSET_WIDTH, 8: offset entry width; MSB = valid, low TYPE_OFFSET_WIDTH-1 bits = byte offset.
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_head_valid  in  1  input beat valid.
- o_head_ready  out  1  input beat accepted when valid & ready.
- i_head  in  HEAD_WIDTH  header window.
- i_type_offset  in  TYPE_NUM*TYPE_OFFSET_WIDTH  entry j at [j*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH].
- o_type_valid  out  1  output beat valid.
- i_type_ready  in  1  downstream accepts.
- o_type  out  TYPE_NUM*TYPE_WIDTH  field j at [j*TYPE_WIDTH +: TYPE_WIDTH].
- o_type_vld  out  TYPE_NUM  bit j = field j extracted (valid offset, in window).
- o_head  out  HEAD_WIDTH  header forwarded with the fields.
- o_oob_cnt  out  16  saturating count of out-of-window field requests.

## Operation
- Field j, offset entry off_j = {v_j, b_j}:
  - v_j=0: field = 0, o_type_vld[j]=0, not counted.
  - v_j=1 and b_j + TB <= HEAD_BYTES: field = bytes b_j..b_j+TB-1, big-endian (byte b_j in MSBs), o_type_vld[j]=1.
  - v_j=1 and b_j + TB > HEAD_BYTES: field = 0, o_type_vld[j]=0, out-of-bounds (OOB). Compare at width TYPE_OFFSET_WIDTH+1; no wrap-around.
- Stage S0: input register (head, offsets, s0_valid). Stage S1: output register (extracted fields, vld mask, head, s1_valid). Extraction is combinational between S0 and S1.
- Advance rules: s1_load = s0_valid & (~s1_valid | i_type_ready); o_head_ready = ~s0_valid | s1_load; S0 loads on i_head_valid & o_head_ready.
- Pipeline states from {s0_valid,s1_valid}: EMPTY(00), ONE(01 or 10), FULL(11). FULL with i_type_ready=0 -> o_head_ready=0, all registers hold.
- o_oob_cnt increments on s1_load by the number of OOB fields in the S0 beat (0..TYPE_NUM); saturates at 0xFFFF, never wraps.
- Outputs o_type, o_type_vld, o_head driven from S1; stable while o_type_valid=1 and i_type_ready=0.

## Timing
- Reset (async assert, sync release): s0_valid=s1_valid=0, o_type_valid=0, o_type=0, o_type_vld=0, o_head=0, o_oob_cnt=0; o_head_ready=1 after reset. Reset mid-traffic drops all in-flight beats, no partial output.
- Latency: beat accepted in cycle N -> o_type_valid in cycle N+2 when downstream ready.
- Throughput: one beat per cycle with i_type_ready held 1.
- o_head_ready depends combinationally on i_type_ready (no register on ready path); max 2 beats buffered.
- Simultaneous S1 consume and S0->S1 load in the same cycle: legal, no bubble. Simultaneous S0 load while S0 moves to S1: legal.
- Beat order preserved; no beat duplicated or dropped absent reset.

## Test plan
- Header byte i = i (0x00..0x3F), offsets {0x8C,0x80,0x00,0x8C} -> o_type field0=0x0C0D, field1=0x0001, field2=0x0000, field3=0x0C0D; o_type_vld=4'b1011; o_type_valid two cycles after accept.
- Boundary: offsets 0xBE (byte 62) and 0xBF (byte 63) -> field=0x3E3F vld=1; field=0 vld=0, o_oob_cnt +1; offset 0xFF -> OOB, counted.
- Streaming: 8 back-to-back beats, i_type_ready=1 -> 8 outputs on 8 consecutive cycles, correct order, o_head matches input.
- Backpressure: i_type_ready=0 for 5 cycles with continuous input -> exactly 2 beats accepted, then o_head_ready=0, outputs stable; release -> remaining beats drain in order, none lost.
- Saturation: preload via 16384 beats each with 4 OOB fields -> o_oob_cnt=0xFFFF and holds on further OOB beats.
- Reset asserted with FULL pipeline -> o_type_valid=0 and o_oob_cnt=0 immediately; after release next beat emerges alone with latency 2.

Source files
------------

// File: rtl/type_field_extract.sv
// -----------------------------------------------------------------------------
// type_field_extract
//
// Two-stage register pipeline that slices TYPE_NUM type fields out of a header
// window and hands them, together with the forwarded header, to the
// type-lookup stage over a valid/ready handshake.
//
//   S0 : input register  (header window, offset entries, s0_valid)
//   S1 : output register (extracted fields, per-field valid mask, header,
//                         s1_valid)
// Extraction is purely combinational between S0 and S1. Both stages may load
// in the same cycle, so the block sustains one beat per clock with the
// downstream ready held high and buffers at most two beats under backpressure.
//
// Offset entry j = {v_j, b_j}: v_j is the MSB, b_j the byte offset into the
// window (byte 0 sits at i_head[HEAD_WIDTH-1 -: 8]). A field is extracted
// big-endian when v_j=1 and b_j + TYPE_WIDTH/8 <= HEAD_WIDTH/8; a valid entry
// that runs past the window end yields 0 and bumps a saturating OOB counter.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_head_valid      input beat valid
//   o_head_ready      input beat accepted when valid & ready (combinational
//                     in i_type_ready)
//   i_head            header window
//   i_type_offset     TYPE_NUM offset entries, entry j at [j*TOW +: TOW]
//   o_type_valid      output beat valid
//   i_type_ready      downstream accepts the output beat
//   o_type            TYPE_NUM fields, field j at [j*TYPE_WIDTH +: TYPE_WIDTH]
//   o_type_vld        bit j set when field j was extracted
//   o_head            header forwarded alongside the fields
//   o_oob_cnt         saturating count of out-of-window field requests
// -----------------------------------------------------------------------------
module type_field_extract #(
  parameter int HEAD_WIDTH        = 512,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_WIDTH        = 16,
  parameter int TYPE_OFFSET_WIDTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_head_valid,
  output logic                             o_head_ready,
  input  logic [HEAD_WIDTH-1:0]            i_head,
  input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] i_type_offset,
  output logic                             o_type_valid,
  input  logic                             i_type_ready,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]   o_type,
  output logic [TYPE_NUM-1:0]              o_type_vld,
  output logic [HEAD_WIDTH-1:0]            o_head,
  output logic [15:0]                      o_oob_cnt
);

  localparam int HEAD_BYTES = HEAD_WIDTH / 8;
  localparam int TB         = TYPE_WIDTH / 8;
  localparam int BOFF_W     = TYPE_OFFSET_WIDTH - 1;  // byte-offset bits
  localparam int END_W      = TYPE_OFFSET_WIDTH + 1;  // end-byte compare width
  localparam int CNT_W      = $clog2(TYPE_NUM + 1);   // per-beat OOB count

  // ---------------------------------------------------------------------------
  // Handshake / advance logic
  // ---------------------------------------------------------------------------
  logic s0_valid_q, s0_valid_d;
  logic s1_valid_q, s1_valid_d;
  logic s0_load;
  logic s1_load;

  // S1 takes the S0 beat whenever it is empty or is being drained this cycle.
  assign s1_load      = s0_valid_q & (~s1_valid_q | i_type_ready);
  // S0 can accept when empty or when its current beat moves on to S1; this
  // is deliberately combinational in i_type_ready so FULL still streams.
  assign o_head_ready = ~s0_valid_q | s1_load;
  assign s0_load      = i_head_valid & o_head_ready;

  assign s0_valid_d = s0_load | (s0_valid_q & ~s1_load);
  assign s1_valid_d = s1_load | (s1_valid_q & ~i_type_ready);

  // ---------------------------------------------------------------------------
  // Stage S0 : input register
  // ---------------------------------------------------------------------------
  logic [HEAD_WIDTH-1:0]                 s0_head_q;
  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] s0_off_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // NOTE: the S0 payload is qualified by s0_valid_q and never observed while
  // invalid, so it carries no reset; this keeps the 500+ flop window off the
  // reset tree.
  always_ff @(posedge i_clk) begin
    if (s0_load) begin
      s0_head_q <= i_head;
      s0_off_q  <= i_type_offset;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational extraction between S0 and S1
  // ---------------------------------------------------------------------------
  logic [TYPE_NUM*TYPE_WIDTH-1:0] type_d;
  logic [TYPE_NUM-1:0]            vld_d;
  logic [CNT_W-1:0]               oob_num;
  logic [HEAD_WIDTH-1:0]          shifted;
  logic [BOFF_W-1:0]              boff;
  logic [END_W-1:0]               end_byte;

  // NOTE: every variable gets a default at the top of the block so no path
  // through the loop can leave one unassigned and infer a latch.
  always_comb begin
    type_d   = '0;
    vld_d    = '0;
    oob_num  = '0;
    shifted  = '0;
    boff     = '0;
    end_byte = '0;
    for (int j = 0; j < TYPE_NUM; j++) begin
      boff     = s0_off_q[j*TYPE_OFFSET_WIDTH +: BOFF_W];
      // One bit wider than the entry so b + TB can never wrap back into range.
      end_byte = {2'b00, boff} + END_W'(TB);
      // Left-aligning the addressed byte puts the field in the window MSBs.
      shifted  = s0_head_q << {boff, 3'b000};
      if (s0_off_q[j*TYPE_OFFSET_WIDTH + TYPE_OFFSET_WIDTH-1]) begin
        if (int'(end_byte) <= HEAD_BYTES) begin
          type_d[j*TYPE_WIDTH +: TYPE_WIDTH] = shifted[HEAD_WIDTH-1 -: TYPE_WIDTH];
          vld_d[j]                           = 1'b1;
        end else begin
          oob_num = oob_num + CNT_W'(1);
        end
      end
    end
  end

  // Saturating OOB accumulation: add in 17 bits and clamp on carry-out.
  logic [16:0] cnt_sum;
  logic [15:0] oob_cnt_q, oob_cnt_d;

  assign cnt_sum   = {1'b0, oob_cnt_q} + 17'(oob_num);
  assign oob_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // ---------------------------------------------------------------------------
  // Stage S1 : output register
  // ---------------------------------------------------------------------------
  logic [TYPE_NUM*TYPE_WIDTH-1:0] s1_type_q;
  logic [TYPE_NUM-1:0]            s1_vld_q;
  logic [HEAD_WIDTH-1:0]          s1_head_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_type_q <= '0;
      s1_vld_q  <= '0;
      s1_head_q <= '0;
      oob_cnt_q <= '0;
    end else if (s1_load) begin
      s1_type_q <= type_d;
      s1_vld_q  <= vld_d;
      s1_head_q <= s0_head_q;
      oob_cnt_q <= oob_cnt_d;
    end
  end

  assign o_type_valid = s1_valid_q;
  assign o_type       = s1_type_q;
  assign o_type_vld   = s1_vld_q;
  assign o_head       = s1_head_q;
  assign o_oob_cnt    = oob_cnt_q;

endmodule

// File: tb/tb_type_field_extract.sv
// -----------------------------------------------------------------------------
// tb_type_field_extract
//
// Scoreboard bench for type_field_extract. A sampler pushes the expected
// response of every accepted beat (from a byte-array reference model) into a
// queue; an independent monitor compares each presented output beat against
// the queue head, checks stability under backpressure and two-cycle latency
// whenever the downstream has not stalled. Directed phases cover the example
// window, window boundaries, streaming, backpressure, counter saturation and
// reset with a full pipeline; a randomized phase covers the rest.
// -----------------------------------------------------------------------------
module tb_type_field_extract;

  localparam int HW  = 512;
  localparam int TN  = 4;
  localparam int TW  = 16;
  localparam int OW  = 8;
  localparam int HB  = HW / 8;
  localparam int TBY = TW / 8;

  logic              i_clk        = 1'b0;
  logic              i_rst        = 1'b0;
  logic              i_head_valid = 1'b0;
  logic              o_head_ready;
  logic [HW-1:0]     i_head       = '0;
  logic [TN*OW-1:0]  i_type_offset = '0;
  logic              o_type_valid;
  logic              i_type_ready = 1'b0;
  logic [TN*TW-1:0]  o_type;
  logic [TN-1:0]     o_type_vld;
  logic [HW-1:0]     o_head;
  logic [15:0]       o_oob_cnt;

  type_field_extract #(
    .HEAD_WIDTH       (HW),
    .TYPE_NUM         (TN),
    .TYPE_WIDTH       (TW),
    .TYPE_OFFSET_WIDTH(OW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_head_valid (i_head_valid),
    .o_head_ready (o_head_ready),
    .i_head       (i_head),
    .i_type_offset(i_type_offset),
    .o_type_valid (o_type_valid),
    .i_type_ready (i_type_ready),
    .o_type       (o_type),
    .o_type_vld   (o_type_vld),
    .o_head       (o_head),
    .o_oob_cnt    (o_oob_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [HW-1:0]    head;
    logic [TN*TW-1:0] typ;
    logic [TN-1:0]    vld;
    logic [15:0]      cnt;
    int               oob;
    int               acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp      = 0;
  int   n_err      = 0;
  int   cyc        = 0;
  int   cum_oob    = 0;
  int   acc_cnt    = 0;
  int   out_cnt    = 0;
  int   last_stall = -1;
  int   first_seen = -1;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: view the window as a byte array and build each field by
  // concatenating TBY consecutive bytes.
  function automatic exp_t model(input logic [HW-1:0] h, input logic [TN*OW-1:0] offs);
    exp_t        e;
    logic [7:0]  bytes [HB];
    logic [OW-1:0] off;
    logic [TW-1:0] f;
    int          b;
    for (int k = 0; k < HB; k++) bytes[k] = h[HW-1-8*k -: 8];
    e.head = h; e.typ = '0; e.vld = '0; e.cnt = '0; e.oob = 0; e.acc = 0;
    for (int j = 0; j < TN; j++) begin
      off = offs[j*OW +: OW];
      b   = int'(off[OW-2:0]);
      if (off[OW-1]) begin
        if (b + TBY <= HB) begin
          f = '0;
          for (int t = 0; t < TBY; t++) f = {f[TW-9:0], bytes[b+t]};
          e.typ[j*TW +: TW] = f;
          e.vld[j] = 1'b1;
        end else begin
          e.oob++;
        end
      end
    end
    return e;
  endfunction

  // Stimulus sampler: record the expected response of every accepted beat.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && i_head_valid && o_head_ready) begin
      e = model(i_head, i_type_offset);
      cum_oob += e.oob;
      e.cnt = (cum_oob > 65535) ? 16'hFFFF : 16'(cum_oob);
      e.acc = cyc;
      sb_q.push_back(e);
      acc_cnt++;
    end
  end

  // Output monitor.
  always @(negedge i_clk) begin
    if (i_rst) begin
      first_seen = -1;
    end else begin
      if (o_type_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got beat head=%h expected no beat", o_head);
        end else begin
          check("o_type",     HW'(o_type),     HW'(sb_q[0].typ));
          check("o_type_vld", HW'(o_type_vld), HW'(sb_q[0].vld));
          check("o_head",     o_head,          sb_q[0].head);
          check("o_oob_cnt",  HW'(o_oob_cnt),  HW'(sb_q[0].cnt));
          if (first_seen < 0) begin
            first_seen = cyc;
            if (last_stall < sb_q[0].acc)
              check("latency", HW'(first_seen - sb_q[0].acc), HW'(2));
          end
          if (i_type_ready) begin
            void'(sb_q.pop_front());
            first_seen = -1;
            out_cnt++;
          end
        end
      end
      if (!i_type_ready) last_stall = cyc;
    end
  end

  task automatic rand_beat(input bit all_oob);
    logic [OW-1:0] off;
    for (int k = 0; k < HW/32; k++) i_head[k*32 +: 32] = $urandom();
    for (int j = 0; j < TN; j++) begin
      if (all_oob) begin
        off = {1'b1, 7'($urandom_range(HB - TBY + 1, 127))};
      end else begin
        off[OW-1] = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 1) == 1) off[OW-2:0] = 7'($urandom_range(0, 127));
        else                           off[OW-2:0] = 7'($urandom_range(HB - 4, HB + 1));
      end
      i_type_offset[j*OW +: OW] = off;
    end
  endtask

  // Hold one beat until accepted; returns at posedge+1 of the cycle after accept.
  task automatic send_one();
    bit got = 1'b0;
    i_head_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge i_clk);
      if (o_head_ready) begin got = 1'b1; break; end
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_head_valid = 1'b0;
    check("send_accepted", HW'(got), HW'(1));
  endtask

  task automatic run_traffic(input int n_beats, input int vpct, input int rpct,
                             input bit all_oob, input bit pending);
    int sent  = 0;
    int guard = 0;
    bit have  = pending;
    while (sent < n_beats && guard < n_beats * 20 + 100) begin
      if (!have && $urandom_range(0, 99) < vpct) begin
        rand_beat(all_oob);
        have = 1'b1;
      end
      i_head_valid = have;
      i_type_ready = ($urandom_range(0, 99) < rpct);
      @(negedge i_clk);
      if (have && o_head_ready) begin have = 1'b0; sent++; end
      @(posedge i_clk); #1;
      guard++;
    end
    i_head_valid = 1'b0;
    check("traffic_sent", HW'(sent), HW'(n_beats));
  endtask

  task automatic drain();
    i_head_valid = 1'b0;
    i_type_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (sb_q.size() == 0) break;
      @(posedge i_clk); #1;
    end
    repeat (3) @(posedge i_clk);
    #1;
    check("drain_empty", HW'(sb_q.size()), HW'(0));
    check("drain_idle",  HW'(o_type_valid), HW'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_acc, base_out, acc_here;
    #1 i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid",  HW'(o_type_valid), HW'(0));
    check("rst_type",   HW'(o_type),       HW'(0));
    check("rst_vld",    HW'(o_type_vld),   HW'(0));
    check("rst_head",   o_head,            HW'(0));
    check("rst_oob",    HW'(o_oob_cnt),    HW'(0));
    i_rst = 1'b0;
    #1;
    check("rst_ready",  HW'(o_head_ready), HW'(1));
    @(posedge i_clk); #1;

    // Example window: byte i = i.
    i_type_ready = 1'b1;
    for (int k = 0; k < HB; k++) i_head[HW-1-8*k -: 8] = 8'(k);
    i_type_offset = {8'h8C, 8'h00, 8'h80, 8'h8C};
    send_one();
    @(negedge i_clk);
    check("ex_not_early", HW'(o_type_valid), HW'(0));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("ex_valid", HW'(o_type_valid), HW'(1));
    check("ex_type",  HW'(o_type),       HW'(64'h0C0D_0000_0001_0C0D));
    check("ex_vld",   HW'(o_type_vld),   HW'(4'b1011));
    @(posedge i_clk); #1;

    // Window boundary: byte 62 fits, byte 63 and 127 do not.
    i_type_offset = {8'h00, 8'hFF, 8'hBF, 8'hBE};
    send_one();
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("bnd_valid", HW'(o_type_valid), HW'(1));
    check("bnd_type",  HW'(o_type),       HW'(64'h0000_0000_0000_3E3F));
    check("bnd_vld",   HW'(o_type_vld),   HW'(4'b0001));
    check("bnd_oob",   HW'(o_oob_cnt),    HW'(16'd2));
    @(posedge i_clk); #1;
    drain();

    // Streaming: 8 back-to-back beats with ready held high.
    run_traffic(8, 100, 100, 1'b0, 1'b0);
    drain();

    // Backpressure: exactly two beats fit before ready drops.
    base_acc = acc_cnt;
    base_out = out_cnt;
    i_type_ready = 1'b0;
    rand_beat(1'b0);
    i_head_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      acc_here = int'(o_head_ready);
      @(posedge i_clk); #1;
      if (acc_here != 0) rand_beat(1'b0);
    end
    @(negedge i_clk);
    check("bp_accepts", HW'(acc_cnt - base_acc), HW'(2));
    check("bp_ready",   HW'(o_head_ready),       HW'(0));
    @(posedge i_clk); #1;
    run_traffic(4, 100, 100, 1'b0, 1'b1);
    drain();
    check("bp_none_lost", HW'(out_cnt - base_out), HW'(acc_cnt - base_acc));

    // Randomized traffic with random valid and ready.
    run_traffic(1500, 70, 70, 1'b0, 1'b0);
    drain();

    // Saturation: 16384 beats of 4 OOB fields each reach 0xFFFF, then hold.
    run_traffic(16400, 100, 100, 1'b1, 1'b0);
    drain();
    check("sat_cnt", HW'(o_oob_cnt), HW'(16'hFFFF));

    // Reset with a full pipeline.
    i_type_ready = 1'b0;
    run_traffic(2, 100, 0, 1'b0, 1'b0);
    i_type_ready = 1'b0;
    @(negedge i_clk);
    check("full_ready", HW'(o_head_ready), HW'(0));
    check("full_valid", HW'(o_type_valid), HW'(1));
    #2 i_rst = 1'b1;
    #1;
    check("mid_rst_valid", HW'(o_type_valid), HW'(0));
    check("mid_rst_oob",   HW'(o_oob_cnt),    HW'(0));
    check("mid_rst_type",  HW'(o_type),       HW'(0));
    check("mid_rst_ready", HW'(o_head_ready), HW'(1));
    sb_q.delete();
    cum_oob = 0;
    @(posedge i_clk); #3;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    base_out = out_cnt;
    i_type_ready = 1'b1;
    rand_beat(1'b0);
    send_one();
    drain();
    check("post_rst_single", HW'(out_cnt - base_out), HW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
